// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline control blocks.
package riscv_pkg;

  localparam int RISCV_DIV_LAT = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_RUN  = 2'd1,
    ST_DIV_DONE = 2'd2
  } stall_state_e;

endpackage

// File: rtl/riscv_stallctrl_cnt.sv
// Divider iteration counter: parallel load, decrement that saturates at zero.
module riscv_stallctrl_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/riscv_stallctrl.sv
// Pipeline stall/flush controller that also sequences the multi-cycle divider.
// Define RISCV_DIV_ZERO_BYPASS_EN to retire divide-by-zero without iterating.
module riscv_stallctrl
  import riscv_pkg::*;
#(
  parameter int DIV_LAT = RISCV_DIV_LAT,
  parameter int CNT_W   = 6
) (
  input  logic             i_riscv_stallctrl_clk,
  input  logic             i_riscv_stallctrl_rst_n,
  input  logic             i_riscv_stallctrl_divreq_e,
  input  logic             i_riscv_stallctrl_divzero_e,
  input  logic             i_riscv_stallctrl_lduse,
  input  logic             i_riscv_stallctrl_pcsrc,
  input  logic             i_riscv_stallctrl_memop_m,
  input  logic             i_riscv_stallctrl_memrdy_m,
  output logic             o_riscv_stallctrl_stallpc,
  output logic             o_riscv_stallctrl_stallfd,
  output logic             o_riscv_stallctrl_stallde,
  output logic             o_riscv_stallctrl_stallem,
  output logic             o_riscv_stallctrl_flushfd,
  output logic             o_riscv_stallctrl_flushde,
  output logic             o_riscv_stallctrl_flushem,
  output logic             o_riscv_stallctrl_divstart,
  output logic             o_riscv_stallctrl_divbusy,
  output logic [CNT_W-1:0] o_riscv_stallctrl_divcnt,
  output logic             o_riscv_stallctrl_divvalid,
  output stall_state_e     o_riscv_stallctrl_state
);

  // Handshake: a divide is accepted when divreq_e is seen in IDLE without a memory
  // wait (divstart marks it); divvalid in DIV_DONE says the result is ready, and EX
  // advances on the first DIV_DONE cycle that has no memory wait.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_LAT - 1);

  stall_state_e state, state_nxt;
  logic         memwait, divzero_hit, unused_divzero;
  logic         cnt_load, cnt_dec, cnt_zero;
  logic [3:0]   stall;  // {pc, fd, de, em}
  logic [2:0]   flush;  // {fd, de, em}
  logic         divstart, divbusy, divvalid;

  assign memwait = i_riscv_stallctrl_memop_m && !i_riscv_stallctrl_memrdy_m;

`ifdef RISCV_DIV_ZERO_BYPASS_EN
  assign divzero_hit    = i_riscv_stallctrl_divzero_e;
  assign unused_divzero = 1'b0;
`else
  assign divzero_hit    = 1'b0;
  assign unused_divzero = i_riscv_stallctrl_divzero_e;
`endif

  always_ff @(posedge i_riscv_stallctrl_clk or negedge i_riscv_stallctrl_rst_n) begin
    if (!i_riscv_stallctrl_rst_n) state <= ST_IDLE;
    else                          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    stall     = 4'b0000;
    flush     = 3'b000;
    divstart  = 1'b0;
    divbusy   = 1'b0;
    divvalid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memwait) begin
          stall = 4'b1111;
        end else if (i_riscv_stallctrl_divreq_e) begin
          stall = 4'b1110;
          flush = 3'b001;
          if (divzero_hit) begin
            state_nxt = ST_DIV_DONE;
          end else begin
            divstart  = 1'b1;
            divbusy   = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = ST_DIV_RUN;
          end
        end else if (i_riscv_stallctrl_pcsrc) begin
          // A taken branch discards the younger load-use pair, so it wins over lduse.
          flush = 3'b110;
        end else if (i_riscv_stallctrl_lduse) begin
          stall = 4'b1100;
          flush = 3'b010;
        end
      end
      ST_DIV_RUN: begin
        divbusy = 1'b1;
        cnt_dec = 1'b1;
        if (memwait) begin
          stall = 4'b1111;
        end else begin
          stall = 4'b1110;
          flush = 3'b001;
        end
        if (cnt_zero) state_nxt = ST_DIV_DONE;
      end
      ST_DIV_DONE: begin
        divvalid = 1'b1;
        if (memwait) stall = 4'b1111;
        else         state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!i_riscv_stallctrl_rst_n) begin
      stall    = 4'b0000;
      flush    = 3'b000;
      divstart = 1'b0;
      divbusy  = 1'b0;
      divvalid = 1'b0;
    end
  end

  riscv_stallctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (i_riscv_stallctrl_clk),
    .rst_n    (i_riscv_stallctrl_rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LOAD_VAL),
    .cnt      (o_riscv_stallctrl_divcnt),
    .zero     (cnt_zero)
  );

  assign {o_riscv_stallctrl_stallpc, o_riscv_stallctrl_stallfd,
          o_riscv_stallctrl_stallde, o_riscv_stallctrl_stallem} = stall;
  assign {o_riscv_stallctrl_flushfd, o_riscv_stallctrl_flushde,
          o_riscv_stallctrl_flushem} = flush;
  assign o_riscv_stallctrl_divstart = divstart;
  assign o_riscv_stallctrl_divbusy  = divbusy;
  assign o_riscv_stallctrl_divvalid = divvalid;
  assign o_riscv_stallctrl_state    = state;

endmodule

// File: tb/tb_riscv_stallctrl.sv
// Self-checking bench for riscv_stallctrl: vector table, corner sequences, random run.
module tb_riscv_stallctrl;
  import riscv_pkg::*;

  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 6;
`ifdef RISCV_DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Output bundle bit positions.
  localparam logic [9:0] O_SPC = 10'b10_0000_0000, O_SFD = 10'b01_0000_0000;
  localparam logic [9:0] O_SDE = 10'b00_1000_0000, O_SEM = 10'b00_0100_0000;
  localparam logic [9:0] O_FFD = 10'b00_0010_0000, O_FDE = 10'b00_0001_0000;
  localparam logic [9:0] O_FEM = 10'b00_0000_1000, O_STA = 10'b00_0000_0100;
  localparam logic [9:0] O_BSY = 10'b00_0000_0010, O_VAL = 10'b00_0000_0001;
  localparam logic [9:0] O_ST3 = O_SPC | O_SFD | O_SDE;
  localparam logic [9:0] O_ST4 = O_ST3 | O_SEM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic divreq = 1'b0, divzero = 1'b0, lduse = 1'b0, pcsrc = 1'b0;
  logic memop = 1'b0, memrdy = 1'b1;
  logic stallpc, stallfd, stallde, stallem, flushfd, flushde, flushem;
  logic divstart, divbusy, divvalid;
  logic [CNT_W-1:0] divcnt;
  stall_state_e dbg_state;
  logic [9:0] act_o;

  always #5 clk = ~clk;

  riscv_stallctrl #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .i_riscv_stallctrl_clk       (clk),
    .i_riscv_stallctrl_rst_n     (rst_n),
    .i_riscv_stallctrl_divreq_e  (divreq),
    .i_riscv_stallctrl_divzero_e (divzero),
    .i_riscv_stallctrl_lduse     (lduse),
    .i_riscv_stallctrl_pcsrc     (pcsrc),
    .i_riscv_stallctrl_memop_m   (memop),
    .i_riscv_stallctrl_memrdy_m  (memrdy),
    .o_riscv_stallctrl_stallpc   (stallpc),
    .o_riscv_stallctrl_stallfd   (stallfd),
    .o_riscv_stallctrl_stallde   (stallde),
    .o_riscv_stallctrl_stallem   (stallem),
    .o_riscv_stallctrl_flushfd   (flushfd),
    .o_riscv_stallctrl_flushde   (flushde),
    .o_riscv_stallctrl_flushem   (flushem),
    .o_riscv_stallctrl_divstart  (divstart),
    .o_riscv_stallctrl_divbusy   (divbusy),
    .o_riscv_stallctrl_divcnt    (divcnt),
    .o_riscv_stallctrl_divvalid  (divvalid),
    .o_riscv_stallctrl_state     (dbg_state)
  );

  assign act_o = {stallpc, stallfd, stallde, stallem, flushfd, flushde, flushem,
                  divstart, divbusy, divvalid};

  int n_vec = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];

  // Reference model: m_t counts cycles since the divide was accepted
  // (-1 = no divide; 1..DIV_LAT = iterating; DIV_LAT+1 = result ready).
  int m_t = -1;
  logic [9:0] s_out;
  logic [CNT_W-1:0] s_cnt;
  int stall_n, start_n, valid_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] model_exp(input logic dq, dz, ld, pc, mo, mr);
    logic mw;
    logic [9:0] o;
    int cnt;
    stall_state_e st;
    mw = mo && !mr;
    o = '0;
    cnt = 0;
    if (m_t < 0) begin
      st = ST_IDLE;
      if (mw)      o = O_ST4;
      else if (dq) o = (BYP && dz) ? (O_ST3 | O_FEM) : (O_ST3 | O_FEM | O_STA | O_BSY);
      else if (pc) o = O_FFD | O_FDE;
      else if (ld) o = O_SPC | O_SFD | O_FDE;
    end else if (m_t <= DIV_LAT) begin
      st = ST_DIV_RUN;
      cnt = DIV_LAT - m_t;
      o = (mw ? O_ST4 : (O_ST3 | O_FEM)) | O_BSY;
    end else begin
      st = ST_DIV_DONE;
      o = O_VAL | (mw ? O_ST4 : 10'b0);
    end
    return {o, CNT_W'(cnt), st};
  endfunction

  task automatic model_adv(input logic dq, dz, mo, mr);
    logic mw;
    mw = mo && !mr;
    if (m_t < 0) begin
      if (!mw && dq) m_t = (BYP && dz) ? DIV_LAT + 1 : 1;
    end else if (m_t <= DIV_LAT) begin
      m_t++;
    end else if (!mw) begin
      m_t = -1;
    end
  endtask

  task automatic step(input logic dq, dz, ld, pc, mo, mr, input string name);
    logic [17:0] e;
    divreq = dq; divzero = dz; lduse = ld; pcsrc = pc; memop = mo; memrdy = mr;
    @(negedge clk);
    exp_q.push_back(model_exp(dq, dz, ld, pc, mo, mr));
    e = exp_q.pop_front();
    s_out = act_o;
    s_cnt = divcnt;
    check(name, 32'({act_o, divcnt, dbg_state}), 32'(e));
    @(posedge clk);
    model_adv(dq, dz, mo, mr);
    #1;
  endtask

  task automatic idle_step(input string name);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, name);
  endtask

  task automatic tally(input int k);
    if (s_out[9]) stall_n++;
    if (s_out[2]) start_n++;
    if (s_out[0] && valid_at < 0) valid_at = k;
  endtask

  task automatic run_divide(input logic dz, input string name);
    stall_n = 0; start_n = 0; valid_at = -1;
    step(1'b1, dz, 1'b0, 1'b0, 1'b0, 1'b1, name);
    tally(0);
    for (int k = 1; k < DIV_LAT + 8 && valid_at < 0; k++) begin
      idle_step(name);
      tally(k);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DIV_LAT + 8 && m_t >= 0; k++) idle_step("drain");
    check("drain_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  typedef struct {
    logic dq, ld, pc, mo, mr;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, O_SPC | O_SFD | O_FDE};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_FFD | O_FDE};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, O_FFD | O_FDE};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, O_SPC | O_SFD | O_FDE};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_ST4};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_ST4};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_ST4};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, O_ST4};

    // Reset: outputs forced low even with requests present.
    divreq = 1'b1; lduse = 1'b1; pcsrc = 1'b1;
    #2;
    check("reset_outputs", 32'({act_o, divcnt, dbg_state}), 32'(0));
    divreq = 1'b0; lduse = 1'b0; pcsrc = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle IDLE behaviour from the table.
    for (int i = 0; i < 9; i++) begin
      divreq = tbl[i].dq; divzero = 1'b0; lduse = tbl[i].ld; pcsrc = tbl[i].pc;
      memop = tbl[i].mo; memrdy = tbl[i].mr;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'({act_o, dbg_state}), 32'({tbl[i].exp, ST_IDLE}));
      @(posedge clk);
      #1;
    end

    // Full-latency divide (held-off request from vec8 now released).
    run_divide(1'b0, "div_full");
    check("div_full_stalls", 32'(stall_n), 32'(DIV_LAT + 1));
    check("div_full_starts", 32'(start_n), 32'(1));
    check("div_full_valid_at", 32'(valid_at), 32'(DIV_LAT + 1));
    drain();

    // Divide by zero: bypassed only when the feature is built in.
    run_divide(1'b1, "div_zero");
    check("div_zero_stalls", 32'(stall_n), BYP ? 32'(1) : 32'(DIV_LAT + 1));
    check("div_zero_starts", 32'(start_n), BYP ? 32'(0) : 32'(1));
    check("div_zero_valid_at", 32'(valid_at), BYP ? 32'(1) : 32'(DIV_LAT + 1));
    drain();

    // Memory wait arriving at divcnt=2 and outlasting the divide.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mw_start");
    for (int k = 1; k < DIV_LAT - 2; k++) idle_step("mw_run");
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "mw_hold");
      if (k == 0) check("mw_cnt_at_entry", 32'(s_cnt), 32'(2));
      check("mw_all_stalls", 32'(s_out[9:6]), 32'(4'hF));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "mw_release");
    check("mw_release_valid", 32'({s_out[9:6], s_out[0]}), 32'(5'b00001));
    drain();

    // Branch held off by a memory wait, flushed on release.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "br_wait");
      check("br_wait_noflush", 32'(s_out[5:4]), 32'(0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "br_release");
    check("br_release_flush", 32'(s_out[5:4]), 32'(2'b11));

    // Reset mid-divide at divcnt=10, then a fresh divide restarts the count.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_start");
    for (int k = 1; k < DIV_LAT - 10; k++) idle_step("rst_run");
    divreq = 1'b1; lduse = 1'b1; pcsrc = 1'b1;
    #2;
    check("rst_precond_cnt", 32'(divcnt), 32'(10));
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'({act_o, divcnt, dbg_state}), 32'(0));
    m_t = -1;
    @(posedge clk);
    #1;
    check("rst_held_outputs", 32'({act_o, divcnt, dbg_state}), 32'(0));
    divreq = 1'b0; lduse = 1'b0; pcsrc = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_restart");
    idle_step("rst_restart_run");
    check("rst_restart_cnt", 32'(s_cnt), 32'(DIV_LAT - 1));
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), "random");
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_stallctrl.md
RISCV_STALLCTRL -- requirements
Module: riscv_stallctrl

Interface
REQ-001 SHALL have parameter DIV_LAT, default 32, divider iteration cycles (range 2..64).
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width; must satisfy 2^CNT_W > DIV_LAT.
REQ-003 SHALL have port i_riscv_stallctrl_clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port i_riscv_stallctrl_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_riscv_stallctrl_divreq_e, input, 1, div/rem instruction valid in EX.
REQ-006 SHALL have port i_riscv_stallctrl_divzero_e, input, 1, divisor operand in EX equals zero.
REQ-007 SHALL have port i_riscv_stallctrl_lduse, input, 1, load-use stall request from the hazard unit.
REQ-008 SHALL have port i_riscv_stallctrl_pcsrc, input, 1, taken branch/jump resolved in EX.
REQ-009 SHALL have port i_riscv_stallctrl_memop_m, input, 1, load/store in MEM.
REQ-010 SHALL have port i_riscv_stallctrl_memrdy_m, input, 1, data memory acknowledge.
REQ-011 SHALL have outputs o_riscv_stallctrl_stallpc, _stallfd, _stallde, _stallem, each 1 bit, hold PC / IF-ID / ID-EX / EX-MEM registers.
REQ-012 SHALL have outputs o_riscv_stallctrl_flushfd, _flushde, _flushem, each 1 bit, bubble into IF-ID / ID-EX / EX-MEM.
REQ-013 SHALL have outputs o_riscv_stallctrl_divstart (1, one-cycle start pulse), _divbusy (1), _divcnt (CNT_W, remaining iterations), _divvalid (1, divider result valid in EX).

Function
REQ-014 SHALL implement FSM states IDLE, DIV_RUN, DIV_DONE.
REQ-015 memwait = memop_m && !memrdy_m; SHALL assert stallpc, stallfd, stallde, stallem in every state while memwait, with highest priority.
REQ-016 In IDLE with divreq_e && !memwait SHALL pulse divstart, load divcnt = DIV_LAT-1, enter DIV_RUN same edge.
REQ-017 In IDLE with divreq_e && memwait SHALL stay IDLE, no divstart, until memwait clears.
REQ-018 In DIV_RUN SHALL decrement divcnt each cycle (independent of memwait); at divcnt==0 enter DIV_DONE.
REQ-019 While divstart or DIV_RUN SHALL assert stallpc, stallfd, stallde, flushem; divbusy=1.
REQ-020 In DIV_DONE SHALL assert divvalid, deassert divbusy; if !memwait release all stalls and enter IDLE next edge, else hold DIV_DONE.
REQ-021 Total divide stall without memwait SHALL be DIV_LAT+1 cycles from divreq_e to EX advance.
REQ-022 In IDLE, no divreq_e, no memwait, lduse=1: SHALL assert stallpc, stallfd, flushde only.
REQ-023 pcsrc=1 with no memwait SHALL assert flushfd, flushde; with memwait flushes SHALL be suppressed (EX frozen, pcsrc re-presented on release).
REQ-024 lduse SHALL be ignored outside IDLE; divreq_e and pcsrc simultaneous SHALL be treated as divreq_e (pcsrc ignored).
REQ-025 divcnt SHALL never underflow; DIV_RUN exits exactly at zero.

Reset
REQ-026 On rst_n low SHALL enter IDLE asynchronously, divcnt=0, all outputs 0, including mid-divide.
REQ-027 Deassertion SHALL take effect on first rising clk edge after release.

Configuration
REQ-028 With RISCV_DIV_ZERO_BYPASS_EN defined, IDLE with divreq_e && divzero_e && !memwait SHALL skip DIV_RUN, go directly to DIV_DONE, no divstart, stall 1 cycle.
REQ-029 Without RISCV_DIV_ZERO_BYPASS_EN, divzero_e SHALL be ignored and divide-by-zero takes the full DIV_LAT path.

Structure
REQ-030 FSM state enum and DIV_LAT default SHALL live in shared package riscv_pkg.
REQ-031 Iteration counter SHALL be sub-module riscv_stallctrl_cnt (load, decrement, zero flag); remainder is one module.

Verification
REQ-032 divreq_e 1 cycle at DIV_LAT=32, memrdy=1 -> divstart 1 cycle, stallpc/fd/de high 33 cycles, divvalid in cycle 33, divcnt 31..0.
REQ-033 lduse=1 one cycle in IDLE -> stallpc=stallfd=flushde=1 that cycle, stallde=stallem=0.
REQ-034 memop_m=1, memrdy_m=0 for 5 cycles during DIV_RUN at divcnt=2 -> counter reaches 0, DIV_DONE held until memrdy, all four stalls high throughout.
REQ-035 pcsrc=1 with memwait 3 cycles -> flushfd/flushde 0 for 3 cycles, 1 on release cycle.
REQ-036 rst_n low at divcnt=10 -> outputs 0 immediately, IDLE, divcnt=0; new divreq_e after release restarts full count.
REQ-037 Macro defined, divreq_e with divzero_e=1 -> no divstart, DIV_DONE next cycle, 1-cycle stall; macro undefined -> 33-cycle stall.
